opb_master_arbiter: RTL and testbench



---
 rtl/opb_arb_pkg.sv | 34 +++
 rtl/opb_master_arbiter_rr_picker.sv | 29 ++
 rtl/opb_master_arbiter.sv | 174 +++++++++++++++++
 tb/tb_opb_master_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_arb_pkg.sv
// Shared types for the OPB master arbiter: FSM states, slave-response
// priority encoding and the transfer-timeout counter width.
package opb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_XFER  = 2'd2
  } arb_state_e;

  // Ordered so that a higher code is a higher-priority response.
  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_ACK   = 2'd1,
    RSP_RETRY = 2'd2,
    RSP_ERR   = 2'd3
  } rsp_e;

  localparam int TOUT_W = 8;

  // Collapse simultaneous slave responses: error beats retry beats ack.
  function automatic rsp_e rsp_resolve(input logic err, input logic retry, input logic ack);
    if (err) begin
      return RSP_ERR;
    end else if (retry) begin
      return RSP_RETRY;
    end else if (ack) begin
      return RSP_ACK;
    end else begin
      return RSP_NONE;
    end
  endfunction

endpackage

// File: rtl/opb_master_arbiter_rr_picker.sv
// Round-robin picker: returns a one-hot vector selecting the first
// requester at or after the pointer, wrapping around. Purely combinational.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;
  logic take;

  // Walk distances 0..N-1 from the pointer; the first hit claims the grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    take  = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        take     = req[j] & ~found & (((int'(ptr) + k) % N) == j);
        grant[j] = grant[j] | take;
        found    = found | take;
      end
    end
  end

endmodule

// File: rtl/opb_master_arbiter.sv
// Round-robin OPB master arbiter. Registers a one-hot grant, muxes the
// granted master's address/data/BE/RNW/select onto the shared segment,
// routes the winning slave response back to the granted master only,
// honours bus lock and terminates stalled transfers after TOUT_CYCLES.
// Packed master write data arrives on M_wrDBus; M_DBus is the read-data return.
// Optional build macro OPB_ARB_PARK_EN: keep the last grant parked while idle.
module opb_master_arbiter
  import opb_arb_pkg::*;
#(
  parameter int N_MASTERS    = 2,
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int TOUT_CYCLES  = 16
) (
  input  logic                               OPB_Clk,
  input  logic                               OPB_Rst,
  input  logic [N_MASTERS-1:0]               M_request,
  input  logic [N_MASTERS-1:0]               M_busLock,
  input  logic [N_MASTERS-1:0]               M_select,
  input  logic [N_MASTERS-1:0]               M_RNW,
  input  logic [N_MASTERS-1:0]               M_seqAddr,
  input  logic [N_MASTERS*C_OPB_AWIDTH-1:0]  M_ABus,
  input  logic [N_MASTERS*C_OPB_DWIDTH/8-1:0] M_BE,
  input  logic [N_MASTERS*C_OPB_DWIDTH-1:0]  M_wrDBus,
  output logic [N_MASTERS-1:0]               M_grant,
  output logic [N_MASTERS-1:0]               M_xferAck,
  output logic [N_MASTERS-1:0]               M_errAck,
  output logic [N_MASTERS-1:0]               M_retry,
  output logic [C_OPB_DWIDTH-1:0]            M_DBus,
  output logic                               OPB_select,
  output logic                               OPB_RNW,
  output logic                               OPB_seqAddr,
  output logic [C_OPB_AWIDTH-1:0]            OPB_ABus,
  output logic [C_OPB_DWIDTH/8-1:0]          OPB_BE,
  output logic [C_OPB_DWIDTH-1:0]            OPB_DBus,
  input  logic                               Sl_xferAck,
  input  logic                               Sl_errAck,
  input  logic                               Sl_retry,
  input  logic                               Sl_toutSup,
  input  logic [C_OPB_DWIDTH-1:0]            Sl_DBus,
  output logic                               OPB_timeout
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int BW = C_OPB_DWIDTH / 8;
`ifdef OPB_ARB_PARK_EN
  localparam logic PARK_EN = 1'b1;
`else
  localparam logic PARK_EN = 1'b0;
`endif

  arb_state_e            state_r;
  logic [N_MASTERS-1:0]  grant_r;
  logic [IW-1:0]         rr_ptr_r;
  logic [TOUT_W-1:0]     tout_cnt_r;

  logic [N_MASTERS-1:0]    pick_s;
  logic [IW-1:0]           rr_next_s;
  logic                    sel_g_s, req_g_s, lock_g_s, seq_g_s, rnw_g_s;
  logic                    owned_s, in_xfer_s, active_s, tout_hit_s, end_s, keep_s;
  logic [TOUT_W-1:0]       cnt_s;
  rsp_e                    rsp_s;
  logic [C_OPB_AWIDTH-1:0] abus_s;
  logic [C_OPB_DWIDTH-1:0] dbus_s;
  logic [BW-1:0]           be_s;

  rr_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
    .req   (M_request),
    .ptr   (rr_ptr_r),
    .grant (pick_s)
  );

  // Per-master controls of the current grant holder (grant is one-hot or zero).
  assign sel_g_s  = |(M_select  & grant_r);
  assign req_g_s  = |(M_request & grant_r);
  assign lock_g_s = |(M_busLock & grant_r);
  assign seq_g_s  = |(M_seqAddr & grant_r);
  assign rnw_g_s  = |(M_RNW     & grant_r);

  // A parked master that requests again owns the bus without waiting a cycle.
  assign owned_s   = (state_r == ST_OWNED) | (PARK_EN & (state_r == ST_IDLE) & req_g_s);
  // The select cycle in OWNED is already the first transfer cycle.
  assign in_xfer_s = (state_r == ST_XFER) | (owned_s & sel_g_s);
  assign active_s  = in_xfer_s & sel_g_s;
  assign cnt_s     = (state_r == ST_XFER) ? tout_cnt_r : '0;

  assign tout_hit_s = active_s & ~Sl_toutSup & ~(Sl_xferAck | Sl_errAck | Sl_retry) &
                      (cnt_s == TOUT_W'(TOUT_CYCLES - 1));
  assign rsp_s  = active_s ? rsp_resolve(Sl_errAck | tout_hit_s, Sl_retry, Sl_xferAck) : RSP_NONE;
  // A dropped select without a response also closes the transfer, silently.
  assign end_s  = in_xfer_s & (~sel_g_s | (rsp_s != RSP_NONE));
  assign keep_s = lock_g_s | (req_g_s & seq_g_s);

  // Next round-robin pointer: the master after the current grant holder.
  always_comb begin
    rr_next_s = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      rr_next_s = grant_r[i] ? ((i == N_MASTERS - 1) ? IW'(0) : IW'(i + 1)) : rr_next_s;
    end
  end

  // AND-OR mux of the granted master's address, byte enables and write data.
  always_comb begin
    abus_s = '0;
    be_s   = '0;
    dbus_s = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      abus_s = abus_s | ({C_OPB_AWIDTH{grant_r[i]}} & M_ABus[i*C_OPB_AWIDTH +: C_OPB_AWIDTH]);
      be_s   = be_s   | ({BW{grant_r[i]}} & M_BE[i*BW +: BW]);
      dbus_s = dbus_s | ({C_OPB_DWIDTH{grant_r[i]}} & M_wrDBus[i*C_OPB_DWIDTH +: C_OPB_DWIDTH]);
    end
  end

  assign M_grant     = grant_r;
  assign M_xferAck   = (rsp_s == RSP_ACK)   ? grant_r : '0;
  assign M_retry     = (rsp_s == RSP_RETRY) ? grant_r : '0;
  assign M_errAck    = (rsp_s == RSP_ERR)   ? grant_r : '0;
  assign M_DBus      = ((rsp_s == RSP_ACK) & rnw_g_s) ? Sl_DBus : '0;
  assign OPB_select  = active_s;
  assign OPB_RNW     = active_s & rnw_g_s;
  assign OPB_seqAddr = active_s & seq_g_s;
  assign OPB_ABus    = active_s ? abus_s : '0;
  assign OPB_BE      = active_s ? be_s : '0;
  assign OPB_DBus    = (active_s & ~rnw_g_s) ? dbus_s : '0;
  assign OPB_timeout = tout_hit_s;

  // Arbitration FSM: grant, round-robin pointer and transfer timeout counter.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      tout_cnt_r <= '0;
    end else if (end_s) begin
      tout_cnt_r <= '0;
      if (keep_s) begin
        state_r <= ST_OWNED;
      end else begin
        state_r  <= ST_IDLE;
        rr_ptr_r <= rr_next_s;
        grant_r  <= PARK_EN ? grant_r : '0;
      end
    end else if (in_xfer_s) begin
      state_r    <= ST_XFER;
      tout_cnt_r <= Sl_toutSup ? cnt_s : cnt_s + TOUT_W'(1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (owned_s) begin
            state_r <= ST_OWNED;
          end else if (|M_request) begin
            grant_r <= pick_s;
            state_r <= ST_OWNED;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_OWNED: begin
          if (!req_g_s && !lock_g_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= rr_next_s;
            grant_r  <= PARK_EN ? grant_r : '0;
          end else begin
            state_r <= ST_OWNED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Directed self-checking bench for opb_master_arbiter (N=2, 32-bit buses,
// TOUT_CYCLES=16, default build without parking).
module tb_opb_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            OPB_Clk = 1'b0;
  logic            OPB_Rst;
  logic [N-1:0]    M_request, M_busLock, M_select, M_RNW, M_seqAddr;
  logic [N*AW-1:0] M_ABus;
  logic [N*BW-1:0] M_BE;
  logic [N*DW-1:0] M_wrDBus;
  logic [N-1:0]    M_grant, M_xferAck, M_errAck, M_retry;
  logic [DW-1:0]   M_DBus;
  logic            OPB_select, OPB_RNW, OPB_seqAddr, OPB_timeout;
  logic [AW-1:0]   OPB_ABus;
  logic [BW-1:0]   OPB_BE;
  logic [DW-1:0]   OPB_DBus;
  logic            Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [DW-1:0]   Sl_DBus;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_master_arbiter #(
    .N_MASTERS(N), .C_OPB_AWIDTH(AW), .C_OPB_DWIDTH(DW), .TOUT_CYCLES(16)
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
    .M_request(M_request), .M_busLock(M_busLock), .M_select(M_select),
    .M_RNW(M_RNW), .M_seqAddr(M_seqAddr), .M_ABus(M_ABus), .M_BE(M_BE),
    .M_wrDBus(M_wrDBus), .M_grant(M_grant), .M_xferAck(M_xferAck),
    .M_errAck(M_errAck), .M_retry(M_retry), .M_DBus(M_DBus),
    .OPB_select(OPB_select), .OPB_RNW(OPB_RNW), .OPB_seqAddr(OPB_seqAddr),
    .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE), .OPB_DBus(OPB_DBus),
    .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
    .Sl_toutSup(Sl_toutSup), .Sl_DBus(Sl_DBus), .OPB_timeout(OPB_timeout)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return 1 ns after the next rising edge, where inputs are changed.
  task automatic cyc();
    @(posedge OPB_Clk);
    #1;
  endtask

  // Granted master m runs one transfer, slave acks after 'waits' idle cycles.
  task automatic xfer(input int m, input int waits, input logic rnw, input logic [DW-1:0] rdata);
    logic [N-1:0] oh;
    oh = '0;
    oh[m] = 1'b1;
    M_select = oh;
    M_RNW[m] = rnw;
    Sl_DBus = rdata;
    for (int i = 0; i < waits; i++) begin
      #1;
      check_val("wait_noack", M_xferAck, 0);
      check_val("wait_dbus0", M_DBus, 0);
      cyc();
    end
    Sl_xferAck = 1'b1;
    #1;
    check_val("xfer_ack", M_xferAck, oh);
    check_val("xfer_abus", OPB_ABus, M_ABus[m*AW +: AW]);
    check_val("xfer_be", OPB_BE, M_BE[m*BW +: BW]);
    check_val("xfer_wdata", OPB_DBus, rnw ? '0 : M_wrDBus[m*DW +: DW]);
    check_val("xfer_rdata", M_DBus, rnw ? rdata : '0);
    check_val("xfer_rnw", OPB_RNW, rnw);
    cyc();
    M_select = '0;
    Sl_xferAck = 1'b0;
    Sl_DBus = '0;
  endtask

  // M0 holds select without ack; find the cycle the arbiter times it out.
  task automatic tout_run(input int sup_cycles, input int exp_cyc);
    int hit;
    hit = 0;
    M_select = 2'b01;
    M_RNW = 2'b01;
    for (int c = 1; c <= 40; c++) begin
      if (hit == 0) begin
        Sl_toutSup = (c <= sup_cycles);
        #1;
        if (OPB_timeout) begin
          hit = c;
          check_val("tout_errack", M_errAck, 2'b01);
        end
        cyc();
      end
    end
    check_val("tout_cycle", hit, exp_cyc);
    M_select = '0;
    M_RNW = '0;
    Sl_toutSup = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    OPB_Rst = 1'b1;
    M_request = '0; M_busLock = '0; M_select = '0; M_RNW = '0; M_seqAddr = '0;
    M_ABus   = {32'h2222_2222, 32'h1000_0000};
    M_BE     = {4'hF, 4'h3};
    M_wrDBus = {32'hCAFE_F00D, 32'h1234_5678};
    Sl_xferAck = 1'b0; Sl_errAck = 1'b0; Sl_retry = 1'b0; Sl_toutSup = 1'b0;
    Sl_DBus = '0;
    repeat (2) @(posedge OPB_Clk);
    #1;

    // Reset holds everything low even with live master/slave activity.
    M_request = 2'b11; M_select = 2'b11; Sl_xferAck = 1'b1; Sl_DBus = 32'hDEAD_BEEF;
    #1;
    check_val("rst_grant", M_grant, 0);
    check_val("rst_select", OPB_select, 0);
    check_val("rst_abus", OPB_ABus, 0);
    check_val("rst_ack", M_xferAck, 0);
    check_val("rst_mdbus", M_DBus, 0);
    check_val("rst_tout", OPB_timeout, 0);
    M_select = '0; Sl_xferAck = 1'b0; Sl_DBus = '0; M_request = '0;
    cyc();
    OPB_Rst = 1'b0;

    // Both request at rr=0: M0 first, then M1.
    M_request = 2'b11;
    #1;
    check_val("grant_latency", M_grant, 0);
    cyc();
    check_val("grant_m0_first", M_grant, 2'b01);
    xfer(0, 0, 1'b0, '0);
    M_request = 2'b10;
    #1;
    check_val("grant_dropped", M_grant, 0);
    cyc();
    check_val("grant_m1_second", M_grant, 2'b10);
    xfer(1, 1, 1'b0, '0);
    M_request = '0;

    // M0 alone, read acked on the third select cycle.
    M_request = 2'b01;
    cyc();
    check_val("grant_m0_alone", M_grant, 2'b01);
    xfer(0, 2, 1'b1, 32'hDEAD_BEEF);
    M_request = '0;
    #1;
    check_val("release_m0", M_grant, 0);

    // Both request at rr=1: M1 first, then M0.
    M_request = 2'b11;
    cyc();
    check_val("grant_m1_first", M_grant, 2'b10);
    xfer(1, 0, 1'b0, '0);
    M_request = 2'b01;
    cyc();
    check_val("grant_m0_after", M_grant, 2'b01);
    xfer(0, 0, 1'b1, 32'h0BAD_CAFE);
    M_request = '0;

    // M0 locks the bus for three transfers while M1 waits.
    M_request = 2'b01; M_busLock = 2'b01;
    cyc();
    check_val("lock_grant", M_grant, 2'b01);
    M_request = 2'b11;
    for (int k = 0; k < 3; k++) begin
      xfer(0, 1, 1'b0, '0);
      check_val("lock_hold", M_grant, 2'b01);
    end
    M_busLock = '0; M_request = 2'b10;
    #1;
    check_val("lock_owned", M_grant, 2'b01);
    cyc();
    check_val("lock_release", M_grant, 0);
    cyc();
    check_val("lock_m1_grant", M_grant, 2'b10);
    xfer(1, 0, 1'b0, '0);
    M_request = '0;

    // Timeout: 16 cycles plain, 26 with toutSup held for the first 10.
    M_request = 2'b01;
    cyc();
    check_val("tout_grant", M_grant, 2'b01);
    tout_run(0, 16);
    M_request = '0;
    #1;
    check_val("tout_release", M_grant, 0);
    M_request = 2'b01;
    cyc();
    tout_run(10, 26);
    M_request = '0;

    // Simultaneous errAck and xferAck on a read: only errAck, no data.
    M_request = 2'b10;
    cyc();
    check_val("prio_grant", M_grant, 2'b10);
    M_select = 2'b10; M_RNW = 2'b10;
    Sl_errAck = 1'b1; Sl_xferAck = 1'b1; Sl_DBus = 32'hDEAD_BEEF;
    #1;
    check_val("prio_err", M_errAck, 2'b10);
    check_val("prio_noack", M_xferAck, 0);
    check_val("prio_nodata", M_DBus, 0);
    cyc();
    M_select = '0; M_RNW = '0; Sl_errAck = 1'b0; Sl_xferAck = 1'b0; Sl_DBus = '0;
    M_request = '0;

    // Retry beats xferAck.
    M_request = 2'b01;
    cyc();
    M_select = 2'b01; Sl_retry = 1'b1; Sl_xferAck = 1'b1;
    #1;
    check_val("prio_retry", M_retry, 2'b01);
    check_val("prio_retry_noack", M_xferAck, 0);
    cyc();
    M_select = '0; Sl_retry = 1'b0; Sl_xferAck = 1'b0;
    M_request = '0;

    // Reset in the middle of a transfer (rr is 1 beforehand).
    M_request = 2'b10;
    cyc();
    M_select = 2'b10;
    cyc();
    #1;
    check_val("mid_select", OPB_select, 1);
    OPB_Rst = 1'b1; Sl_xferAck = 1'b1;
    #1;
    check_val("mid_rst_grant", M_grant, 0);
    check_val("mid_rst_select", OPB_select, 0);
    check_val("mid_rst_ack", M_xferAck, 0);
    check_val("mid_rst_abus", OPB_ABus, 0);
    cyc();
    OPB_Rst = 1'b0; Sl_xferAck = 1'b0; M_select = '0;
    M_request = 2'b11;
    #1;
    check_val("post_rst_latency", M_grant, 0);
    cyc();
    check_val("post_rst_rr0", M_grant, 2'b01);
    M_request = '0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
